// File: rtl/fri_v_pkg.sv
// Shared slot-state constants for the free-slot bitmap and its priority encoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents:
//   SLOT_FREE / SLOT_BUSY : meaning of one bit of the free bitmap.
package fri_v_pkg;

  // A set bitmap bit marks a slot that may be granted.
  localparam logic SLOT_FREE = 1'b1;
  localparam logic SLOT_BUSY = 1'b0;

endpackage : fri_v_pkg

// File: rtl/lzd.sv
// Priority encoder: index of the lowest free slot in a bitmap, as a two-level radix-B tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input vector directly.
//
// Parameters:
//   N : vector width (power of two)
//   B : radix of the group tree, 2 or 4
// Ports:
//   i_vec   in  N  bitmap, SLOT_FREE marks a candidate
//   o_valid out 1  at least one candidate present
//   o_index out M  lowest candidate index (0 when o_valid is low)
module lzd
  import fri_v_pkg::*;
#(
  parameter  int N = 8,
  parameter  int B = 4,
  localparam int M = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic         o_valid,
  output logic [M-1:0] o_index
);

  if (B != 2 && B != 4) begin : g_bad_base
    $error("lzd: B must be 2 or 4");
  end

  // Groups of B bits; the vector is zero-padded when N is not a multiple of B.
  localparam int G = (N + B - 1) / B;
  localparam int P = G * B;

  logic [P-1:0] vec_pad;
  logic [G-1:0] grp_any;
  logic [B-1:0] grp_bits;
  int           grp_sel;
  int           bit_sel;

  assign vec_pad = P'(i_vec);

  // First level: which groups contain a candidate.
  always_comb begin
    grp_any = '0;
    for (int g = 0; g < G; g++) begin
      for (int k = 0; k < B; k++) begin
        if (vec_pad[g*B+k] == SLOT_FREE) begin
          grp_any[g] = 1'b1;
        end
      end
    end
  end

  // Second level: lowest group, then lowest bit inside it. Scanning downwards
  // lets the last hit (lowest index) win.
  always_comb begin
    grp_sel = 0;
    for (int g = G - 1; g >= 0; g--) begin
      if (grp_any[g]) begin
        grp_sel = g;
      end
    end

    grp_bits = vec_pad[grp_sel*B +: B];

    bit_sel = 0;
    for (int k = B - 1; k >= 0; k--) begin
      if (grp_bits[k] == SLOT_FREE) begin
        bit_sel = k;
      end
    end
  end

  assign o_valid = |grp_any;
  assign o_index = o_valid ? M'(grp_sel * B + bit_sel) : '0;

endmodule : lzd

// File: rtl/slot_allocator.sv
// Free-slot allocator: grants the lowest free tag, accepts releases and a global flush.
// Latency: offer is combinational from the registered bitmap; fire/free/flush take effect next edge.
// Backpressure: offer holds until i_alloc_ready; o_alloc_valid drops when full or during flush.
//
// Parameters:
//   N : number of slots, power of two >= 2
//   B : radix forwarded to the lzd priority stage (2 or 4)
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_flush                release every slot; drops alloc and free in that cycle
//   o_alloc_valid/_index   offered slot (lowest free index)
//   i_alloc_ready          consumer takes the offered slot
//   i_free_valid/_index    slot release request
//   o_free_count, o_full   number of free slots, and "none free"
//   o_error                sticky double-free indication
// Optional build: SLOT_ALLOCATOR_FREE_BYPASS_EN forwards a released slot straight to the
// consumer in the same cycle when no slot is free.
module slot_allocator
  import fri_v_pkg::*;
#(
  parameter  int N = 8,
  parameter  int B = 4,
  localparam int M = $clog2(N),
  localparam int C = M + 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  output logic         o_alloc_valid,
  output logic [M-1:0] o_alloc_index,
  input  logic         i_alloc_ready,
  input  logic         i_free_valid,
  input  logic [M-1:0] i_free_index,
  output logic [C-1:0] o_free_count,
  output logic         o_full,
  output logic         o_error
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("slot_allocator: N must be a power of two >= 2");
  end

  logic [N-1:0] bitmap_q, bitmap_d;
  logic [C-1:0] count_q, count_d;
  logic         error_q, error_d;

  logic         lzd_vld;
  logic [M-1:0] lzd_idx;
  logic         fire;
  logic         free_req;
  logic         dbl_free;
  logic         free_ok;
  logic [C:0]   cnt_ext;

  lzd #(
    .N (N),
    .B (B)
  ) u_lzd (
    .i_vec   (bitmap_q),
    .o_valid (lzd_vld),
    .o_index (lzd_idx)
  );

  assign free_req = i_free_valid && !i_flush;

`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
  // With every slot busy, a slot being released can be handed on directly.
  logic bypass_act;
  assign bypass_act = (bitmap_q == '0) && free_req;

  always_comb begin
    o_alloc_valid = !i_flush && (lzd_vld || bypass_act);
    o_alloc_index = bypass_act ? i_free_index : lzd_idx;
  end
`else
  always_comb begin
    o_alloc_valid = !i_flush && lzd_vld;
    o_alloc_index = lzd_idx;
  end
`endif

  assign fire = o_alloc_valid && i_alloc_ready;

  // Releasing a slot that is already free is a protocol error. This also covers
  // a same-cycle release of the slot being offered, since an offered slot is free.
  assign dbl_free = free_req && (bitmap_q[i_free_index] == SLOT_FREE);
  assign free_ok  = free_req && !dbl_free;

  // Count delta in one extra bit so underflow shows up as the top bit.
  assign cnt_ext = {1'b0, count_q} + (C+1)'(free_ok) - (C+1)'(fire);

  always_comb begin
    bitmap_d = bitmap_q;
    count_d  = count_q;
    error_d  = error_q | dbl_free;

    if (i_flush) begin
      bitmap_d = '1;
      count_d  = C'(N);
    end else begin
      // Release first, then grant: a bypassed slot is set and cleared again,
      // so it stays busy and the count nets to zero.
      if (free_ok) begin
        bitmap_d[i_free_index] = SLOT_FREE;
      end
      if (fire) begin
        bitmap_d[o_alloc_index] = SLOT_BUSY;
      end

      if (cnt_ext[C]) begin
        count_d = '0;
      end else if (cnt_ext > (C+1)'(N)) begin
        count_d = C'(N);
      end else begin
        count_d = cnt_ext[C-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bitmap_q <= '1;
      count_q  <= C'(N);
      error_q  <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  assign o_free_count = count_q;
  assign o_full       = (count_q == '0);
  assign o_error      = error_q;

endmodule : slot_allocator

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator (N=8, B=4): vector table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_slot_allocator;

  localparam int N = 8;
  localparam int M = 3;
  localparam int C = 4;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_flush;
  logic         o_alloc_valid;
  logic [M-1:0] o_alloc_index;
  logic         i_alloc_ready;
  logic         i_free_valid;
  logic [M-1:0] i_free_index;
  logic [C-1:0] o_free_count;
  logic         o_full;
  logic         o_error;

  slot_allocator #(.N(N), .B(4)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .o_alloc_valid (o_alloc_valid),
    .o_alloc_index (o_alloc_index),
    .i_alloc_ready (i_alloc_ready),
    .i_free_valid  (i_free_valid),
    .i_free_index  (i_free_index),
    .o_free_count  (o_free_count),
    .o_full        (o_full),
    .o_error       (o_error)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model: one flag per slot ----------------
  bit m_free[N];
  bit m_err;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_free[i] = 1'b1;
    m_err = 1'b0;
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_free[i]) n++;
    return n;
  endfunction

  function automatic void m_offer(input bit fl, input bit fv, input int fi,
                                  output bit v, output int idx);
    v = 1'b0;
    idx = 0;
    if (!fl) begin
      for (int i = N - 1; i >= 0; i--) if (m_free[i]) begin v = 1'b1; idx = i; end
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
      if (!v && fv) begin v = 1'b1; idx = fi; end
`endif
    end
  endfunction

  function automatic void m_step(input bit fl, input bit rd, input bit fv, input int fi);
    bit v;
    int idx;
    bit was_free;
    bit handoff;
    m_offer(fl, fv, fi, v, idx);
    if (fl) begin
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
    end else begin
      handoff = 1'b0;
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
      handoff = (m_pop() == 0) && fv && rd;
`endif
      if (!handoff) begin
        was_free = m_free[fi];
        if (v && rd) m_free[idx] = 1'b0;
        if (fv) begin
          if (was_free) m_err = 1'b1;
          else m_free[fi] = 1'b1;
        end
      end
    end
  endfunction

  // One clock: drive, sample at negedge and check against the model, advance model, edge.
  task automatic cycle(input logic fl, input logic rd, input logic fv, input int fi,
                       output int sv, output int si, output int sc, output int se);
    bit ev;
    int ei;
    int pc;
    i_flush = fl; i_alloc_ready = rd; i_free_valid = fv; i_free_index = M'(fi);
    @(negedge i_clk);
    sv = int'(o_alloc_valid); si = int'(o_alloc_index);
    sc = int'(o_free_count);  se = int'(o_error);
    m_offer(fl, fv, fi, ev, ei);
    pc = m_pop();
    chk("model_valid", sv, int'(ev));
    if (ev) chk("model_index", si, ei);
    chk("model_count_popcount", sc, pc);
    chk("model_full", int'(o_full), int'(pc == 0));
    chk("model_error", se, int'(m_err));
    m_step(fl, rd, fv, fi);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(output int sv, output int si, output int sc, output int se);
    cycle(1'b0, 1'b0, 1'b0, 0, sv, si, sc, se);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"}, int'(o_alloc_valid), 1);
    chk({nm, "_index"}, int'(o_alloc_index), 0);
    chk({nm, "_count"}, int'(o_free_count), N);
    chk({nm, "_full"},  int'(o_full), 0);
    chk({nm, "_error"}, int'(o_error), 0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next clock edge.
  task automatic async_reset(input string nm);
    i_flush = 1'b0; i_alloc_ready = 1'b0; i_free_valid = 1'b0; i_free_index = '0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals(nm);
    #3;
    i_rst_n = 1'b1;
    m_reset();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic fl, rd, fv;
    int   fi;
    int   ev, ei, ec, ee;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int sv, si, sc, se;
    int fi;
    bit fl, rd, fv;

    i_rst_n = 1'b0; i_flush = 1'b0; i_alloc_ready = 1'b0;
    i_free_valid = 1'b0; i_free_index = '0;
    m_reset();
    #12;
    chk_reset_vals("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // ---- table: drain all 8 slots, then free 5 while full ----
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 0, 1, i, N - i, 0};
`ifdef SLOT_ALLOCATOR_FREE_BYPASS_EN
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5, 1, 5, 0, 0};
`else
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5, 0, 0, 0, 0};
`endif
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 0, 1, 5, 1, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 1, 5, 1, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].fl, vecs[i].rd, vecs[i].fv, vecs[i].fi, sv, si, sc, se);
      chk($sformatf("vec%0d_valid", i), sv, vecs[i].ev);
      if (vecs[i].ev != 0) chk($sformatf("vec%0d_index", i), si, vecs[i].ei);
      chk($sformatf("vec%0d_count", i), sc, vecs[i].ec);
      chk($sformatf("vec%0d_error", i), se, vecs[i].ee);
    end

    // ---- same-cycle alloc(4) + free(2) from bitmap 1111_0000 ----
    async_reset("rst_a");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 0, sv, si, sc, se);
    cycle(1'b0, 1'b1, 1'b1, 2, sv, si, sc, se);
    chk("allocfree_offer_before", si, 4);
    idle(sv, si, sc, se);
    chk("allocfree_next_index", si, 2);
    chk("allocfree_count", sc, 4);

    // ---- double free of slot 6: sticky error, count unchanged, survives flush ----
    cycle(1'b0, 1'b0, 1'b1, 6, sv, si, sc, se);
    idle(sv, si, sc, se);
    chk("dblfree_error", se, 1);
    chk("dblfree_count", sc, 4);
    idle(sv, si, sc, se);
    chk("dblfree_error_held", se, 1);
    cycle(1'b1, 1'b1, 1'b0, 0, sv, si, sc, se);
    chk("flush_valid_low", sv, 0);
    idle(sv, si, sc, se);
    chk("flush_error_kept", se, 1);
    chk("flush_count", sc, N);

    // ---- alloc X + free X same cycle: alloc applies, error flagged ----
    async_reset("rst_b");
    cycle(1'b0, 1'b1, 1'b1, 0, sv, si, sc, se);
    idle(sv, si, sc, se);
    chk("samex_error", se, 1);
    chk("samex_count", sc, 7);
    chk("samex_index", si, 1);

    // ---- flush with 5 busy and ready high: no fire ----
    async_reset("rst_c");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 0, sv, si, sc, se);
    cycle(1'b1, 1'b1, 1'b1, 1, sv, si, sc, se);
    chk("flush5_valid", sv, 0);
    chk("flush5_count_before", sc, 3);
    idle(sv, si, sc, se);
    chk("flush5_count", sc, N);
    chk("flush5_index", si, 0);
    chk("flush5_error", se, 0);

    // ---- randomized traffic against the model, with async resets between blocks ----
    for (int blk = 0; blk < 6; blk++) begin
      async_reset($sformatf("rst_rand%0d", blk));
      for (int n = 0; n < 60; n++) begin
        fl = ($urandom_range(15) == 0);
        rd = 1'($urandom_range(1));
        fv = 1'($urandom_range(1));
        fi = $urandom_range(N - 1);
        if ($urandom_range(3) != 0) begin
          for (int t = 0; t < N; t++) begin
            if (!m_free[(fi + t) % N]) begin
              fi = (fi + t) % N;
              break;
            end
          end
        end
        cycle(fl, rd, fv, fi, sv, si, sc, se);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule : tb_slot_allocator
